// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues one instruction-memory read per cycle
// (fixed 1-cycle read latency) and buffers the returned instructions in a
// DEPTH-entry queue that feeds decode through a valid/ready handshake.
// A redirect reloads the PC and flushes both queued and in-flight fetches.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   redirect_valid/pc  load a new fetch PC and flush everything this cycle
//   imem_req/addr      read request and address (address is the current PC)
//   imem_rdata         read data, returned the cycle after imem_req
//   out_valid/ready    head-of-queue handshake towards decode
//   out_instr/pc/npc   head instruction, its PC and PC + PC_STEP
//   q_count            occupied queue entries
//
// Optional feature (define FETCH_QUEUE_PERF_EN):
//   perf_fetched       responses written into the queue (wraps at 2^32)
//   perf_flushed       entries plus in-flight responses discarded by redirects
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_instr,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_npc,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_flushed
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    entry_t            head_entry;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              not_empty;
    logic              issue;
    logic              enq;
    logic              deq;
    logic [OCC_W-1:0]  occupancy;

    // Issue/enqueue/dequeue qualifiers. The in-flight slot is counted as
    // occupied so a returning response always finds a free entry.
    always_comb begin
        not_empty = (count_q != '0);
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);
        issue     = rst_n && !redirect_valid && (occupancy < OCC_W'(DEPTH));
        enq       = inflight_q && !redirect_valid;
        deq       = not_empty && !redirect_valid && out_ready;
    end

    // Output drive; head fields read as zero while the queue is empty.
    always_comb begin
        head_entry = fifo_q[head_q];
        imem_req   = issue;
        imem_addr  = pc_q;
        out_valid  = not_empty && !redirect_valid;
        out_instr  = not_empty ? head_entry.instr : '0;
        out_pc     = not_empty ? head_entry.pc : '0;
        out_npc    = not_empty ? head_entry.pc + XLEN'(PC_STEP) : '0;
        q_count    = count_q;
    end

    // Next-state: redirect overrides issue, enqueue and dequeue.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + XLEN'(PC_STEP);
            end
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are only observed through a nonzero count,
    // so no reset is needed here.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[tail_q] <= {imem_rdata, inflight_pc_q};
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    // A redirect discards the whole queue plus any response returning now.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(enq);
        perf_flushed_d = perf_flushed_q;
        if (redirect_valid) begin
            perf_flushed_d = perf_flushed_q + 32'(count_q) + 32'(inflight_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
